// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window generator and kernel: pixel width default and 3x3 tap indices.
package sobel_pkg;

  localparam int unsigned PIX_W_DEFAULT = 8;
  localparam int unsigned WIN_TAPS      = 9;

  // Tap Trc = window row offset r, column offset c; index 8 sits in the MSB slot of out_win.
  localparam int unsigned T00 = 8;
  localparam int unsigned T10 = 7;
  localparam int unsigned T20 = 6;
  localparam int unsigned T01 = 5;
  localparam int unsigned T11 = 4;
  localparam int unsigned T21 = 3;
  localparam int unsigned T02 = 2;
  localparam int unsigned T12 = 1;
  localparam int unsigned T22 = 0;

  function automatic int unsigned tap_lsb(input int unsigned tap, input int unsigned pix_w);
    return tap * pix_w;
  endfunction

endpackage

// File: rtl/sobel_window_stream_if.sv
// Pixel-in / window-out stream bundle; master drives pixels and consumes windows.
interface sobel_window_stream_if
  import sobel_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEFAULT
);

  logic [PIX_W-1:0]          in_pix;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIN_TAPS*PIX_W-1:0] out_win;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_first;
  logic                      out_last;
  logic                      frame_done;

  modport master (
    output in_pix, in_valid, out_ready,
    input  in_ready, out_win, out_valid, out_first, out_last, frame_done
  );

  modport slave (
    input  in_pix, in_valid, out_ready,
    output in_ready, out_win, out_valid, out_first, out_last, frame_done
  );

endinterface

// File: rtl/sobel_line_buffer.sv
// Two-line pixel store: combinational read of rows r-2/r-1 at col, shifted down on each accepted pixel.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter  int unsigned IMG_W  = 640,
  parameter  int unsigned PIX_W  = PIX_W_DEFAULT,
  localparam int unsigned ADDR_W = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [PIX_W-1:0]  wdata,
  output logic [PIX_W-1:0]  rd_a_c,
  output logic [PIX_W-1:0]  rd_b_c
);

  logic [PIX_W-1:0] line_a [IMG_W];
  logic [PIX_W-1:0] line_b [IMG_W];

  // Read-before-write: the current column sees the old contents in the accept cycle.
  assign rd_a_c = line_a[addr];
  assign rd_b_c = line_b[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      line_a[addr] <= line_b[addr];
      line_b[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_window_stream.sv
// Streaming 3x3 window generator: raster pixels in, one packed window per interior top-left position out.
module sobel_window_stream
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned PIX_W = PIX_W_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  clear,
  sobel_window_stream_if.slave bus
);

  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam int unsigned COLV_W = 3 * PIX_W;
  localparam int unsigned WIN_W  = WIN_TAPS * PIX_W;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [PIX_W-1:0]  rd_a_c;
  logic [PIX_W-1:0]  rd_b_c;
  logic [COLV_W-1:0] col_q1;
  logic [COLV_W-1:0] col_q2;
  logic [COLV_W-1:0] col_new_c;
  logic [WIN_W-1:0]  win_c;
  logic              accept_c;
  logic              col_end_c;
  logic              row_end_c;
  logic              emit_c;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept_c     = bus.in_valid && bus.in_ready && !clear;
  assign col_end_c    = (col == COL_W'(IMG_W - 1));
  assign row_end_c    = (row == ROW_W'(IMG_H - 1));
  assign emit_c       = accept_c && (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign col_new_c    = {rd_a_c, rd_b_c, bus.in_pix};

  sobel_line_buffer #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W)
  ) u_line_buffer (
    .clk    (clk),
    .addr   (col),
    .we     (accept_c),
    .wdata  (bus.in_pix),
    .rd_a_c (rd_a_c),
    .rd_b_c (rd_b_c)
  );

  // Two stored columns plus the incoming column form the 3x3 array; each column is {row r, r+1, r+2}.
  always_comb begin
    win_c = '0;
    win_c[tap_lsb(T00, PIX_W) +: PIX_W] = col_q1[2*PIX_W +: PIX_W];
    win_c[tap_lsb(T10, PIX_W) +: PIX_W] = col_q1[1*PIX_W +: PIX_W];
    win_c[tap_lsb(T20, PIX_W) +: PIX_W] = col_q1[0*PIX_W +: PIX_W];
    win_c[tap_lsb(T01, PIX_W) +: PIX_W] = col_q2[2*PIX_W +: PIX_W];
    win_c[tap_lsb(T11, PIX_W) +: PIX_W] = col_q2[1*PIX_W +: PIX_W];
    win_c[tap_lsb(T21, PIX_W) +: PIX_W] = col_q2[0*PIX_W +: PIX_W];
    win_c[tap_lsb(T02, PIX_W) +: PIX_W] = col_new_c[2*PIX_W +: PIX_W];
    win_c[tap_lsb(T12, PIX_W) +: PIX_W] = col_new_c[1*PIX_W +: PIX_W];
    win_c[tap_lsb(T22, PIX_W) +: PIX_W] = col_new_c[0*PIX_W +: PIX_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col            <= '0;
      row            <= '0;
      col_q1         <= '0;
      col_q2         <= '0;
      bus.out_win    <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_first  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.frame_done <= 1'b0;
    end else if (clear) begin
      col            <= '0;
      row            <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_first  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= accept_c && col_end_c && row_end_c;
      if (accept_c) begin
        col_q1 <= col_q2;
        col_q2 <= col_new_c;
        col    <= col_end_c ? '0 : col + COL_W'(1);
        if (col_end_c) begin
          row <= row_end_c ? '0 : row + ROW_W'(1);
        end
      end
      // Output register only loads on accept, which implies the previous window has retired.
      if (emit_c) begin
        bus.out_win   <= win_c;
        bus.out_valid <= 1'b1;
        bus.out_first <= (row == ROW_W'(2)) && (col == COL_W'(2));
        bus.out_last  <= row_end_c && col_end_c;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_stream.sv
// Directed bench for sobel_window_stream: 8x6 frame model checks plus a 3x3 minimum-size instance.
module tb_sobel_window_stream;
  import sobel_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned H   = 6;
  localparam int unsigned PW  = 8;
  localparam int          WPF = (H - 2) * (W - 2);

  logic clk = 1'b0;
  logic reset;
  logic clear;

  always #5 clk = ~clk;

  sobel_window_stream_if #(.PIX_W(PW)) bus ();
  sobel_window_stream_if #(.PIX_W(PW)) bus3 ();

  sobel_window_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  sobel_window_stream #(.IMG_W(3), .IMG_H(3), .PIX_W(PW)) dut3 (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus3)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cur_f, cur_r, cur_c, n_acc, exp_idx, fd_cnt, first_cnt, last_cnt, stall_left;
  logic [71:0] seen_first, seen_last;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int f, input int r, input int c);
    return 8'(r * 16 + c + f * 96);
  endfunction

  function automatic logic [71:0] exp_win(input int f, input int r, input int c);
    logic [71:0] w = '0;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 3; i++)
        w = (w << 8) | 72'(pix(f, r + i, c + j));
    return w;
  endfunction

  task automatic model_reset();
    cur_f = 0; cur_r = 0; cur_c = 0; n_acc = 0; exp_idx = 0;
    fd_cnt = 0; first_cnt = 0; last_cnt = 0; stall_left = 0;
  endtask

  // One cycle: drive at negedge, observe handshakes, update model, wait for next negedge.
  task automatic step(input logic v, input logic rdy);
    int wi;
    bus.in_valid  = v;
    bus.in_pix    = pix(cur_f, cur_r, cur_c);
    bus.out_ready = rdy;
    #1;
    if (bus.frame_done) fd_cnt++;
    check_eq("in_ready", 72'(bus.in_ready), 72'(!bus.out_valid || rdy));
    if (bus.out_valid) begin
      wi = exp_idx % WPF;
      check_eq("win", bus.out_win, exp_win(exp_idx / WPF, wi / (W - 2), wi % (W - 2)));
      check_eq("first", 72'(bus.out_first), 72'(wi == 0));
      check_eq("last", 72'(bus.out_last), 72'(wi == WPF - 1));
      if (rdy) begin
        if (wi == 0) begin first_cnt++; seen_first = bus.out_win; end
        if (wi == WPF - 1) begin last_cnt++; seen_last = bus.out_win; end
        exp_idx++;
      end
    end
    if (v && bus.in_ready) begin
      n_acc++;
      cur_c++;
      if (cur_c == W) begin
        cur_c = 0; cur_r++;
        if (cur_r == H) begin cur_r = 0; cur_f++; end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n_pix, input int n_win, input bit rnd);
    int cyc;
    logic v, r;
    cyc = 0;
    while ((n_acc < n_pix || exp_idx < n_win) && cyc < 4000) begin
      v = (n_acc < n_pix) && (!rnd || $urandom_range(0, 1) == 1);
      r = !rnd || $urandom_range(0, 1) == 1;
      if (stall_left > 0 && bus.out_valid && exp_idx == 2) begin
        r = 1'b0;
        stall_left--;
        check_eq("stall_win", bus.out_win, 72'h021222031323041424);
      end
      step(v, r);
      cyc++;
    end
    check_eq("no_timeout", 72'(cyc < 4000), 72'(1));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_win"}, bus.out_win, 72'(0));
    check_eq({tag, "_valid"}, 72'(bus.out_valid), 72'(0));
    check_eq({tag, "_first"}, 72'(bus.out_first), 72'(0));
    check_eq({tag, "_last"}, 72'(bus.out_last), 72'(0));
    check_eq({tag, "_done"}, 72'(bus.frame_done), 72'(0));
    check_eq({tag, "_ready"}, 72'(bus.in_ready), 72'(1));
  endtask

  initial begin
    int n3, fd3;
    reset = 1'b0; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_pix = '0; bus.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_pix = '0; bus3.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_idle("rst");
    reset = 1'b1;
    @(negedge clk);

    // Continuous stream, consumer always ready
    run(W * H, WPF, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    check_eq("t1_count", 72'(exp_idx), 72'(WPF));
    check_eq("t1_done", 72'(fd_cnt), 72'(1));
    check_eq("t1_first", seen_first, 72'h001020011121021222);
    check_eq("t1_last", seen_last, 72'h354555364656374757);

    // Five-cycle stall on window #3
    model_reset();
    stall_left = 5;
    run(W * H, WPF, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    check_eq("t2_stalls", 72'(stall_left), 72'(0));
    check_eq("t2_count", 72'(exp_idx), 72'(WPF));
    check_eq("t2_done", 72'(fd_cnt), 72'(1));

    // Random handshakes over three back-to-back frames
    model_reset();
    run(3 * W * H, 3 * WPF, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    check_eq("t3_count", 72'(exp_idx), 72'(3 * WPF));
    check_eq("t3_firsts", 72'(first_cnt), 72'(3));
    check_eq("t3_lasts", 72'(last_cnt), 72'(3));
    check_eq("t3_done", 72'(fd_cnt), 72'(3));

    // Reset asserted at pixel (3,4)
    model_reset();
    run(3 * W + 4, 0, 1'b0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1 check_idle("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run(W * H, WPF, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    check_eq("t4_count", 72'(exp_idx), 72'(WPF));
    check_eq("t4_first", seen_first, 72'h001020011121021222);
    check_eq("t4_done", 72'(fd_cnt), 72'(1));

    // Clear coincident with pixel (2,6)
    model_reset();
    run(2 * W + 6, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_pix = pix(0, 2, 6);
    bus.out_ready = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    #1 check_eq("clr_valid", 72'(bus.out_valid), 72'(0));
    model_reset();
    run(W * H, WPF, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    check_eq("t5_count", 72'(exp_idx), 72'(WPF));
    check_eq("t5_first", seen_first, 72'h001020011121021222);

    // Minimum 3x3 frame
    n3 = 0; fd3 = 0;
    bus3.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus3.in_valid = 1'b1;
      bus3.in_pix = pix(0, i / 3, i % 3);
      #1 check_eq("t6_pre_valid", 72'(bus3.out_valid), 72'(0));
      @(negedge clk);
    end
    bus3.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus3.frame_done) fd3++;
      if (bus3.out_valid) begin
        n3++;
        check_eq("t6_win", bus3.out_win, 72'h001020011121021222);
        check_eq("t6_first", 72'(bus3.out_first), 72'(1));
        check_eq("t6_last", 72'(bus3.out_last), 72'(1));
      end
      @(negedge clk);
    end
    check_eq("t6_count", 72'(n3), 72'(1));
    check_eq("t6_done", 72'(fd3), 72'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
